// File: rtl/clk_period_meter_pkg.sv
// Shared types and constants for the clock period meter.
package clk_period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  localparam int unsigned AVG_SAMPLES = 4;
  localparam int unsigned AVG_LOG2    = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchroniser for an asynchronous input followed by a registered
// rising-edge detector. Reusable for any sniffer input.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  // Fewer than two stages would not give metastability protection.
  localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of sig_in in clk_in cycles and hands results out over valid/ready.
// Optional build macro CLK_PERIOD_METER_AVG_EN reports the mean of four consecutive periods.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             overflow,
  output logic             overrun,
  output logic             busy
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic             sig_rise;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic             new_res;
  logic [WIDTH-1:0] res;

`ifdef CLK_PERIOD_METER_AVG_EN
  localparam int unsigned ACC_W = WIDTH + AVG_LOG2;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic [AVG_LOG2-1:0] smp_q, smp_d;
`endif

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .d     (sig_in),
    .rise  (sig_rise)
  );

  // Next-state, counter, result and handshake logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    ovr_d    = ovr_q;
    new_res  = 1'b0;
    res      = cnt_q;
`ifdef CLK_PERIOD_METER_AVG_EN
    acc_d    = acc_q;
    smp_d    = smp_q;
    acc_sum  = acc_q + ACC_W'(cnt_q);
`endif

    unique case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        valid_d = 1'b0;
        ovf_d   = 1'b0;
        ovr_d   = 1'b0;
        if (enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (sig_rise) begin
          cnt_d   = WIDTH'(1);
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        // Each edge closes the running period and opens the next one.
        if (sig_rise) begin
          cnt_d = WIDTH'(1);
`ifdef CLK_PERIOD_METER_AVG_EN
          smp_d = smp_q + AVG_LOG2'(1);
          if (smp_q == AVG_LOG2'(AVG_SAMPLES - 1)) begin
            new_res = 1'b1;
            res     = WIDTH'(acc_sum >> AVG_LOG2);
            acc_d   = '0;
          end else begin
            acc_d = acc_sum;
          end
`else
          new_res = 1'b1;
          res     = cnt_q;
`endif
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + WIDTH'(1);
          if (cnt_q == CNT_MAX - WIDTH'(1)) ovf_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE) begin
      if (valid_q && period_ready) valid_d = 1'b0;
      // An unconsumed result blocks the new one, which is then lost.
      if (new_res) begin
        if (!valid_q || period_ready) begin
          period_d = res;
          valid_d  = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      ovr_d   = 1'b0;
`ifdef CLK_PERIOD_METER_AVG_EN
      acc_d   = '0;
      smp_d   = '0;
`endif
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      ovr_q    <= ovr_d;
      busy_q   <= busy_d;
    end
  end

`ifdef CLK_PERIOD_METER_AVG_EN
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      smp_q <= '0;
    end else begin
      acc_q <= acc_d;
      smp_q <= smp_d;
    end
  end
`endif

  assign period       = period_q;
  assign period_valid = valid_q;
  assign overflow     = ovf_q;
  assign overrun      = ovr_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: a 16-bit instance plus a 4-bit instance
// sharing the same stimulus (the narrow one exercises saturation).
module tb_clk_period_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        sig_in = 1'b0;
  logic        period_ready = 1'b0;
  logic [15:0] period;
  logic        period_valid, overflow, overrun, busy;
  logic [3:0]  s_period;
  logic        s_valid, s_ovf, s_ovr, s_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int per_l[4] = '{32, 32, 32, 32};
  int gi = 0;
  int ph = 0;

  clk_period_meter #(.WIDTH(16), .SYNC_STAGES(2)) u_dut (
    .clk_in(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
    .period(period), .period_valid(period_valid), .period_ready(period_ready),
    .overflow(overflow), .overrun(overrun), .busy(busy)
  );

  clk_period_meter #(.WIDTH(4), .SYNC_STAGES(2)) u_small (
    .clk_in(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
    .period(s_period), .period_valid(s_valid), .period_ready(period_ready),
    .overflow(s_ovf), .overrun(s_ovr), .busy(s_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse-train source: rising edges spaced by per_l[] in turn.
  always @(negedge clk) begin
    if (ph + 1 >= per_l[gi]) begin
      ph = 0;
      gi = (gi + 1) % 4;
    end else begin
      ph = ph + 1;
    end
    sig_in = (ph < ((per_l[gi] / 2 > 0) ? per_l[gi] / 2 : 1));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_valid(input string tag, input int budget, output int t);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (period_valid) begin
        t = cyc;
        return;
      end
    end
    t = cyc;
    check(tag, 32'd0, 32'd1);
  endtask

  // Restart the source with a new period list while disabled, then enable.
  task automatic start_meas(input int p0, input int p1, input int p2, input int p3);
    enable = 1'b0;
    per_l[0] = p0; per_l[1] = p1; per_l[2] = p2; per_l[3] = p3;
    gi = 3;
    ph = p3 - 1;
    sig_in = 1'b0;
    repeat (6) tick();
    enable = 1'b1;
  endtask

  int t0, t1, v0, v1, nv;

  initial begin
    repeat (3) tick();
    check("rst_period", 32'(period), 32'd0);
    check("rst_valid", 32'(period_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_small_busy", 32'(s_busy), 32'd0);
    check("rst_small_overrun", 32'(s_ovr), 32'd0);
    #2 rst_n = 1'b1;
    tick();

`ifdef CLK_PERIOD_METER_AVG_EN
    period_ready = 1'b1;
    start_meas(10, 11, 12, 13);
    wait_valid("avg_mix_timeout", 200, t0);
    check("avg_mix_period", 32'(period), 32'd11);
    check("avg_mix_small", 32'(s_period), 32'd11);
    check("avg_mix_small_ovf", 32'(s_ovf), 32'd0);
    start_meas(20, 20, 20, 20);
    wait_valid("avg_20_timeout", 250, t0);
    check("avg_20_period", 32'(period), 32'd20);
    check("avg_20_small_sat", 32'(s_period), 32'd15);
    check("avg_20_small_ovf", 32'(s_ovf), 32'd1);
    nv = 0;
    while (cyc < t0 + 79) begin
      tick();
      if (period_valid) nv++;
    end
    check("avg_once_per_four", 32'(nv), 32'd0);
    tick();
    check("avg_20_next_valid", 32'(period_valid), 32'd1);
    check("avg_20_next_period", 32'(period), 32'd20);
`else
    // 1: period 32, consumer always ready
    period_ready = 1'b1;
    start_meas(32, 32, 32, 32);
    wait_valid("p32_timeout", 120, t0);
    check("p32_period", 32'(period), 32'd32);
    check("p32_overflow", 32'(overflow), 32'd0);
    check("p32_overrun", 32'(overrun), 32'd0);
    check("p32_busy", 32'(busy), 32'd1);
    wait_valid("p32_second_timeout", 40, t1);
    check("p32_second_period", 32'(period), 32'd32);
    check("p32_spacing", 32'(t1 - t0), 32'd32);

    // 2: 40-cycle period saturates the 4-bit instance
    start_meas(40, 40, 40, 40);
    wait_valid("p40_timeout", 140, t0);
    check("p40_wide_period", 32'(period), 32'd40);
    check("p40_wide_ovf", 32'(overflow), 32'd0);
    check("p40_small_period", 32'(s_period), 32'd15);
    check("p40_small_ovf", 32'(s_ovf), 32'd1);
    wait_valid("p40_second_timeout", 50, t1);
    check("p40_small_ovf_sticky", 32'(s_ovf), 32'd1);
    check("p40_small_period2", 32'(s_period), 32'd15);
    enable = 1'b0;
    tick();
    check("p40_ovf_cleared", 32'(s_ovf), 32'd0);
    check("p40_busy_off", 32'(busy), 32'd0);
    enable = 1'b1;

    // 3: overrun with alternating 8/12 periods
    period_ready = 1'b0;
    start_meas(8, 12, 8, 12);
    wait_valid("ovr_timeout", 100, t0);
    v0 = int'(period);
    v1 = 20 - v0;
    check("ovr_first_val", 32'(v0 == 8 || v0 == 12), 32'd1);
    check("ovr_first_clean", 32'(overrun), 32'd0);
    wait_until(t0 + v1);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_held_period", 32'(period), 32'(v0));
    check("ovr_held_valid", 32'(period_valid), 32'd1);
    wait_until(t0 + 20 + v1 - 1);
    period_ready = 1'b1;
    wait_until(t0 + 20 + v1);
    period_ready = 1'b0;
    check("ovr_reload_valid", 32'(period_valid), 32'd1);
    check("ovr_reload_period", 32'(period), 32'(v1));
    tick();
    check("ovr_stable_period", 32'(period), 32'(v1));
    check("ovr_stable_valid", 32'(period_valid), 32'd1);

    // 4: abort mid-period, then need two fresh edges
    period_ready = 1'b1;
    start_meas(32, 32, 32, 32);
    wait_valid("abort_timeout", 120, t0);
    wait_until(t0 + 10);
    enable = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(period_valid), 32'd0);
    enable = 1'b1;
    tick();
    check("abort_rearm_busy", 32'(busy), 32'd1);
    nv = 0;
    while (cyc < t0 + 63) begin
      tick();
      if (period_valid) nv++;
    end
    check("abort_no_early_result", 32'(nv), 32'd0);
    tick();
    check("abort_result_valid", 32'(period_valid), 32'd1);
    check("abort_result_period", 32'(period), 32'd32);

    // 5: asynchronous reset between clock edges
    repeat (10) tick();
    check("areset_pre_period", 32'(period), 32'd32);
    #3 rst_n = 1'b0;
    #1;
    check("areset_period", 32'(period), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_valid", 32'(period_valid), 32'd0);
    check("areset_small_period", 32'(s_period), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    start_meas(2, 2, 2, 2);
    wait_valid("p2_timeout", 30, t0);
    check("p2_period", 32'(period), 32'd2);
    wait_valid("p2_second_timeout", 5, t1);
    check("p2_second_period", 32'(period), 32'd2);
    check("p2_spacing", 32'(t1 - t0), 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
